// File: rtl/z88_bus_pkg.sv
// Shared Z80 bus definitions: FSM states, cycle types and request payload.
// Used by the bus initiator and by the Blink bench monitor.
package z88_bus_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_WAIT = 7;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_e;

  typedef enum logic [2:0] {
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_M1,
    CYC_IO_RD,
    CYC_IO_WR
  } cyc_e;

  typedef struct packed {
    cyc_e              cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Opcode fetch overrides the write flag; I/O is never combined with M1.
  function automatic cyc_e decode_cyc(input logic io, input logic wr, input logic m1);
    if (m1)      return CYC_M1;
    else if (io) return wr ? CYC_IO_WR : CYC_IO_RD;
    else         return wr ? CYC_MEM_WR : CYC_MEM_RD;
  endfunction

  function automatic logic cyc_is_io(input cyc_e c);
    return (c == CYC_IO_RD) || (c == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_wr(input cyc_e c);
    return (c == CYC_MEM_WR) || (c == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/z88_sync2.sv
// Two-flop synchroniser for an asynchronous active-low input; resets to 1.
//  clk   in  sampling clock
//  rst_n in  asynchronous active-low reset
//  d     in  asynchronous input
//  q     out synchronised level
module z88_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 2'b11;
    else        ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/z80_bus_initiator.sv
// Z80 bus master for the Blink: converts a one-word req/ack transaction into
// Z80-timed memory, I/O and M1 cycles, and synchronises INT/NMI back.
//  mck, rin_n                  clock, async active-low reset
//  req, req_io/wr/m1, req_addr, req_wdata   transaction request (sampled in IDLE)
//  ack, rdata, busy            transaction completion / read data / in-flight
//  ca, cdi, cdo                Z80 address, write data out, read data in
//  mrq_n, ior_n, crd_n, cm1_n  Z80 strobes
//  intb_n, nmib_n              async Blink interrupts
//  int_pend, nmi_pend, nmi_clr interrupt status (nmi sticky until cleared)
module z80_bus_initiator
  import z88_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 0
) (
  input  logic              mck,
  input  logic              rin_n,
  input  logic              req,
  input  logic              req_io,
  input  logic              req_wr,
  input  logic              req_m1,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ca,
  output logic [DATA_W-1:0] cdi,
  input  logic [DATA_W-1:0] cdo,
  output logic              mrq_n,
  output logic              ior_n,
  output logic              crd_n,
  output logic              cm1_n,
  input  logic              intb_n,
  input  logic              nmib_n,
  output logic              int_pend,
  output logic              nmi_pend,
  input  logic              nmi_clr
);

  // Total TW states per cycle type; I/O always has one built-in TW.
  localparam int unsigned      TW_W   = CNT_W + 1;
  localparam logic [TW_W-1:0] MEM_TW = TW_W'(MEM_WAIT);
  localparam logic [TW_W-1:0] IO_TW  = TW_W'(IO_WAIT + 1);

  state_e              state_q, state_d;
  cyc_e                cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ca_q, ca_d;
  logic [DATA_W-1:0]   cdi_q, cdi_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mrq_n_q, mrq_n_d;
  logic                ior_n_q, ior_n_d;
  logic                crd_n_q, crd_n_d;
  logic                cm1_n_q, cm1_n_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                nmi_prev_q, nmi_prev_d;
  logic                nmi_pend_q, nmi_pend_d;

  req_t                req_in;
  logic [TW_W-1:0]     tw_total;
  logic                int_sync;
  logic                nmi_sync;

  // Interrupt input synchronisers.
  z88_sync2 u_int_sync (.clk(mck), .rst_n(rin_n), .d(intb_n), .q(int_sync));
  z88_sync2 u_nmi_sync (.clk(mck), .rst_n(rin_n), .d(nmib_n), .q(nmi_sync));

  assign req_in = '{cyc: decode_cyc(req_io, req_wr, req_m1), addr: req_addr, wdata: req_wdata};
  assign tw_total = cyc_is_io(cyc_q) ? IO_TW : MEM_TW;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    cnt_d      = cnt_q;
    ca_d       = ca_q;
    cdi_d      = cdi_q;
    rdata_d    = rdata_q;
    mrq_n_d    = mrq_n_q;
    ior_n_d    = ior_n_q;
    crd_n_d    = crd_n_q;
    cm1_n_d    = cm1_n_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_T1;
          cyc_d   = req_in.cyc;
          ca_d    = req_in.addr;
          busy_d  = 1'b1;
          if (cyc_is_wr(req_in.cyc)) cdi_d = req_in.wdata;
          // Memory and M1 strobes are driven from T1.
          if (!cyc_is_io(req_in.cyc)) begin
            mrq_n_d = 1'b0;
            crd_n_d = cyc_is_wr(req_in.cyc);
            cm1_n_d = (req_in.cyc != CYC_M1);
          end
        end
      end
      S_T1: begin
        state_d = S_T2;
        // I/O strobes start one state later than memory strobes.
        if (cyc_is_io(cyc_q)) begin
          ior_n_d = 1'b0;
          crd_n_d = cyc_is_wr(cyc_q);
        end
      end
      S_T2: begin
        if (tw_total == '0) begin
          state_d = S_T3;
        end else begin
          state_d = S_TW;
          cnt_d   = CNT_W'(tw_total - TW_W'(1));
        end
      end
      S_TW: begin
        if (cnt_q == '0) state_d = S_T3;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_T3: begin
        state_d = S_IDLE;
        if (!cyc_is_wr(cyc_q)) rdata_d = cdo;
        mrq_n_d = 1'b1;
        ior_n_d = 1'b1;
        crd_n_d = 1'b1;
        cm1_n_d = 1'b1;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky NMI on a falling synchronised edge; a new edge beats a clear.
    nmi_prev_d = nmi_sync;
    nmi_pend_d = (nmi_prev_q & ~nmi_sync) | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= CYC_MEM_RD;
      cnt_q      <= '0;
      ca_q       <= '0;
      cdi_q      <= '0;
      rdata_q    <= '0;
      mrq_n_q    <= 1'b1;
      ior_n_q    <= 1'b1;
      crd_n_q    <= 1'b1;
      cm1_n_q    <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      ca_q       <= ca_d;
      cdi_q      <= cdi_d;
      rdata_q    <= rdata_d;
      mrq_n_q    <= mrq_n_d;
      ior_n_q    <= ior_n_d;
      crd_n_q    <= crd_n_d;
      cm1_n_q    <= cm1_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ca       = ca_q;
  assign cdi      = cdi_q;
  assign mrq_n    = mrq_n_q;
  assign ior_n    = ior_n_q;
  assign crd_n    = crd_n_q;
  assign cm1_n    = cm1_n_q;
  assign int_pend = ~int_sync;
  assign nmi_pend = nmi_pend_q;

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Directed bench for z80_bus_initiator: two instances (no waits / extra waits)
// share all inputs except req; a vector table drives single transactions.
module tb_z80_bus_initiator;

  logic        mck = 1'b0;
  logic        rin_n;
  logic        req0, req_w;
  logic        req_io, req_wr, req_m1;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, cdo;
  logic        intb_n, nmib_n, nmi_clr;

  logic        ack0, busy0, mrq0, ior0, crd0, cm10, intp0, nmip0;
  logic [7:0]  rdata0, cdi0;
  logic [15:0] ca0;
  logic        ack_w, busy_w, mrq_w, ior_w, crd_w, cm1_w, intp_w, nmip_w;
  logic [7:0]  rdata_w, cdi_w;
  logic [15:0] ca_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 mck = ~mck;

  z80_bus_initiator #(.MEM_WAIT(0), .IO_WAIT(0)) dut0 (
    .mck(mck), .rin_n(rin_n), .req(req0), .req_io(req_io), .req_wr(req_wr),
    .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack0),
    .rdata(rdata0), .busy(busy0), .ca(ca0), .cdi(cdi0), .cdo(cdo),
    .mrq_n(mrq0), .ior_n(ior0), .crd_n(crd0), .cm1_n(cm10), .intb_n(intb_n),
    .nmib_n(nmib_n), .int_pend(intp0), .nmi_pend(nmip0), .nmi_clr(nmi_clr)
  );

  z80_bus_initiator #(.MEM_WAIT(2), .IO_WAIT(2)) dut_w (
    .mck(mck), .rin_n(rin_n), .req(req_w), .req_io(req_io), .req_wr(req_wr),
    .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack_w),
    .rdata(rdata_w), .busy(busy_w), .ca(ca_w), .cdi(cdi_w), .cdo(cdo),
    .mrq_n(mrq_w), .ior_n(ior_w), .crd_n(crd_w), .cm1_n(cm1_w), .intb_n(intb_n),
    .nmib_n(nmib_n), .int_pend(intp_w), .nmi_pend(nmip_w), .nmi_clr(nmi_clr)
  );

  typedef struct packed {
    logic        ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] ca;
    logic [7:0]  cdi;
    logic        mrq_n, ior_n, crd_n, cm1_n;
  } obs_t;

  // sel, io, wr, m1, addr, wdata, cdo, ack cycle, low-cycle counts
  typedef struct {
    bit          sel;
    bit          io, wr, m1;
    logic [15:0] addr;
    logic [7:0]  wd, cdo;
    int          ack, mrq, ior, rd, m1c;
  } vec_t;

  vec_t        tbl[10];
  logic [7:0]  rmodel[2];

  function automatic obs_t observe(input bit sel);
    obs_t o;
    if (sel) o = '{ack_w, rdata_w, busy_w, ca_w, cdi_w, mrq_w, ior_w, crd_w, cm1_w};
    else     o = '{ack0, rdata0, busy0, ca0, cdi0, mrq0, ior0, crd0, cm10};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mck);
    #1;
  endtask

  // One transaction over a fixed 12-cycle window; cdo carries the data only
  // in the expected T3 cycle so capture timing is exercised.
  task automatic run_vec(input int idx, input vec_t v);
    obs_t        o;
    int          ack_at, n_ack, mrq_lo, ior_lo, rd_lo, m1_lo, first_lo, busy_cnt;
    logic [15:0] ca1, ca_ack;
    logic [7:0]  cdi1, rdat;
    string       p;
    p = $sformatf("v%0d", idx);
    ack_at = -1; n_ack = 0; mrq_lo = 0; ior_lo = 0; rd_lo = 0; m1_lo = 0;
    first_lo = -1; busy_cnt = 0; ca1 = '0; ca_ack = '0; cdi1 = '0; rdat = '0;
    req_io = v.io; req_wr = v.wr; req_m1 = v.m1; req_addr = v.addr;
    req_wdata = v.wd; cdo = 8'hEE;
    if (v.sel) req_w = 1'b1; else req0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      o = observe(v.sel);
      if (!o.mrq_n) mrq_lo++;
      if (!o.ior_n) ior_lo++;
      if (!o.crd_n) rd_lo++;
      if (!o.cm1_n) m1_lo++;
      if ((!o.mrq_n || !o.ior_n) && first_lo < 0) first_lo = k;
      if (o.busy) busy_cnt++;
      if (o.ack) begin
        n_ack++;
        if (ack_at < 0) begin ack_at = k; rdat = o.rdata; ca_ack = o.ca; end
      end
      if (k == 1) begin
        ca1 = o.ca; cdi1 = o.cdi;
        // Scramble the request while busy; it must be ignored.
        req0 = 1'b0; req_w = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wd;
        req_io = ~v.io; req_wr = ~v.wr;
      end
      cdo = (k == v.ack - 1) ? v.cdo : 8'hEE;
    end
    if (!(v.wr && !v.m1)) rmodel[v.sel] = v.cdo;
    chk({p, "_ack_cycle"}, ack_at, v.ack);
    chk({p, "_ack_count"}, n_ack, 1);
    chk({p, "_mrq_low"}, mrq_lo, v.mrq);
    chk({p, "_ior_low"}, ior_lo, v.ior);
    chk({p, "_crd_low"}, rd_lo, v.rd);
    chk({p, "_cm1_low"}, m1_lo, v.m1c);
    chk({p, "_first_strobe"}, first_lo, v.io ? 2 : 1);
    chk({p, "_busy_cycles"}, busy_cnt, v.ack - 1);
    chk({p, "_ca_t1"}, ca1, v.addr);
    chk({p, "_ca_hold"}, ca_ack, v.addr);
    if (v.wr && !v.m1) chk({p, "_cdi"}, cdi1, v.wd);
    chk({p, "_rdata"}, rdat, rmodel[v.sel]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acks[$];
    int   hi_cnt;
    obs_t o;

    tbl[0] = '{0, 0, 0, 0, 16'h4123, 8'h00, 8'h5A, 4, 3, 0, 3, 0};
    tbl[1] = '{0, 1, 1, 0, 16'h40B0, 8'h04, 8'h00, 5, 0, 3, 0, 0};
    tbl[2] = '{0, 0, 1, 0, 16'h8000, 8'hA5, 8'h00, 4, 3, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 0, 16'h12FE, 8'h00, 8'h3C, 5, 0, 3, 3, 0};
    tbl[4] = '{0, 0, 0, 1, 16'h0100, 8'h00, 8'hC3, 4, 3, 0, 3, 3};
    tbl[5] = '{0, 0, 1, 1, 16'h1234, 8'h66, 8'h11, 4, 3, 0, 3, 3};
    tbl[6] = '{1, 0, 0, 1, 16'h0000, 8'h00, 8'h77, 6, 5, 0, 5, 5};
    tbl[7] = '{1, 0, 1, 0, 16'hFFFF, 8'h81, 8'h00, 6, 5, 0, 0, 0};
    tbl[8] = '{1, 1, 0, 0, 16'h00FF, 8'h00, 8'h99, 7, 0, 5, 5, 0};
    tbl[9] = '{0, 0, 0, 0, 16'h2000, 8'h00, 8'h00, 4, 3, 0, 3, 0};
    rmodel[0] = 8'h00;
    rmodel[1] = 8'h00;

    rin_n = 1'b0; req0 = 1'b0; req_w = 1'b0; req_io = 1'b0; req_wr = 1'b0;
    req_m1 = 1'b0; req_addr = 16'h0; req_wdata = 8'h0; cdo = 8'h0;
    intb_n = 1'b1; nmib_n = 1'b1; nmi_clr = 1'b0;
    repeat (3) tick();

    // Reset state
    o = observe(0);
    chk("rst_ca", o.ca, 16'h0);
    chk("rst_cdi", o.cdi, 8'h0);
    chk("rst_rdata", o.rdata, 8'h0);
    chk("rst_strobes", {o.mrq_n, o.ior_n, o.crd_n, o.cm1_n}, 4'hF);
    chk("rst_ack_busy", {o.ack, o.busy}, 2'b00);
    chk("rst_irq", {intp0, nmip0, intp_w, nmip_w}, 4'h0);
    o = observe(1);
    chk("rst_w_outs", {o.ack, o.busy, o.mrq_n, o.ior_n, o.crd_n, o.cm1_n, o.ca}, {6'b001111, 16'h0});
    rin_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Back-to-back memory writes with req held high
    req_io = 1'b0; req_wr = 1'b1; req_m1 = 1'b0; req_addr = 16'h3000;
    req_wdata = 8'h5C; req0 = 1'b1;
    hi_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (ack0) acks.push_back(k);
      if (k <= 11 && mrq0 && ior0 && crd0 && cm10) hi_cnt++;
      if (k == 11) req0 = 1'b0;
    end
    chk("b2b_ack_count", acks.size(), 3);
    if (acks.size() == 3) begin
      chk("b2b_ack0", acks[0], 4);
      chk("b2b_ack1", acks[1], 8);
      chk("b2b_ack2", acks[2], 12);
    end
    chk("b2b_idle_gaps", hi_cnt, 2);
    chk("b2b_rdata_kept", rdata0, 8'h00);

    // Reset during T2 of an I/O read
    req_io = 1'b1; req_wr = 1'b0; req_m1 = 1'b0; req_addr = 16'h5511; cdo = 8'hEE;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    chk("abort_t2_ior", {ior0, crd0}, 2'b00);
    rin_n = 1'b0;
    #1;
    chk("abort_strobes", {mrq0, ior0, crd0, cm10}, 4'hF);
    chk("abort_busy", busy0, 1'b0);
    repeat (2) tick();
    rin_n = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack0) hi_cnt++;
    end
    chk("abort_no_ack", hi_cnt, 0);
    chk("abort_rdata", rdata0, 8'h00);
    rmodel[0] = 8'h00;
    rmodel[1] = 8'h00;
    run_vec(10, '{0, 0, 0, 0, 16'h6789, 8'h00, 8'h42, 4, 3, 0, 3, 0});

    // INT synchronisation latency
    intb_n = 1'b0;
    tick();
    chk("int_1edge", intp0, 1'b0);
    tick();
    chk("int_2edge", {intp0, intp_w}, 2'b11);
    intb_n = 1'b1;
    repeat (2) tick();
    chk("int_release", intp0, 1'b0);

    // NMI: clear coinciding with the detected edge loses to the set
    nmib_n = 1'b0;
    repeat (2) tick();
    chk("nmi_pre", nmip0, 1'b0);
    nmi_clr = 1'b1;
    tick();
    chk("nmi_set_wins", nmip0, 1'b1);
    tick();
    chk("nmi_cleared", nmip0, 1'b0);
    nmi_clr = 1'b0;

    // NMI stays pending until cleared
    nmib_n = 1'b1;
    repeat (3) tick();
    nmib_n = 1'b0;
    repeat (6) tick();
    chk("nmi_sticky", {nmip0, nmip_w}, 2'b11);
    nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0;
    tick();
    chk("nmi_clr2", nmip0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
